// File: rtl/trdb_stream_packer.sv
// Trace stream packer: packs variable-length packets LSB-first into WORD_W-bit words
// and queues them in a registered DEPTH-entry FIFO with a valid/grant handshake.
module trdb_stream_packer #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned PKT_W  = 64,
  parameter int unsigned LEN_W  = $clog2(PKT_W + 1),
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [PKT_W-1:0]         packet_i,
  input  logic [LEN_W-1:0]         packet_len_i,
  input  logic                     packet_valid_i,
  output logic                     packet_ready_o,
  input  logic                     flush_i,
  output logic [WORD_W-1:0]        word_o,
  output logic                     word_valid_o,
  input  logic                     grant_i,
  output logic [LEN_W:0]           fill_o,
  output logic [$clog2(DEPTH):0]   fifo_level_o,
  output logic                     busy_o
);

  localparam int unsigned STAGE_W = WORD_W - 1 + PKT_W;
  localparam int unsigned FILL_W  = LEN_W + 1;
  localparam int unsigned AW      = $clog2(DEPTH);

  localparam logic [FILL_W-1:0] WordFill  = FILL_W'(WORD_W);
  localparam logic [AW:0]       DepthLvl  = (AW + 1)'(DEPTH);

  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               flush_q, flush_d;
  logic [AW:0]        wptr_q, wptr_d;
  logic [AW:0]        rptr_q, rptr_d;
  logic [WORD_W-1:0]  mem_q [DEPTH];

  logic [AW:0]        level;
  logic               empty;
  logic               full;
  logic               pop;
  logic               can_push;
  logic               ready;
  logic               accept;
  logic               drain_full;
  logic               drain_part;
  logic               push;
  logic [WORD_W-1:0]  push_word;
  logic [PKT_W-1:0]   pkt_mask;
  logic [STAGE_W-1:0] pkt_wide;

  always_comb begin
    level      = wptr_q - rptr_q;
    empty      = (level == '0);
    full       = (level == DepthLvl);
    pop        = !empty && grant_i;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    can_push   = !full || pop;
    ready      = (fill_q < WordFill) && !flush_q;
    accept     = packet_valid_i && ready;
    drain_full = (fill_q >= WordFill) && can_push;
    drain_part = flush_q && (fill_q != '0) && (fill_q < WordFill) && can_push;
    push       = drain_full || drain_part;
    push_word  = stage_q[WORD_W-1:0];
    // Shifting by PKT_W yields zero, so a full-length packet keeps every bit.
    pkt_mask   = ~({PKT_W{1'b1}} << packet_len_i);
    pkt_wide   = STAGE_W'(packet_i & pkt_mask);
  end

  always_comb begin
    stage_d = stage_q;
    fill_d  = fill_q;
    if (accept) begin
      stage_d = stage_q | (pkt_wide << fill_q);
      fill_d  = fill_q + FILL_W'(packet_len_i);
    end else if (drain_full) begin
      stage_d = stage_q >> WORD_W;
      fill_d  = fill_q - WordFill;
    end else if (drain_part) begin
      // Bits above fill are always zero, so the low word is already padded.
      stage_d = '0;
      fill_d  = '0;
    end
  end

  always_comb begin
    flush_d = flush_q;
    if (flush_q) begin
      if (drain_part || (drain_full && (fill_q == WordFill)) || (fill_q == '0)) begin
        flush_d = 1'b0;
      end
    end else if (flush_i && ((fill_q != '0) || accept)) begin
      flush_d = 1'b1;
    end
  end

  always_comb begin
    wptr_d = wptr_q + (AW + 1)'(push);
    rptr_d = rptr_q + (AW + 1)'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= '0;
      fill_q  <= '0;
      flush_q <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      stage_q <= stage_d;
      fill_q  <= fill_d;
      flush_q <= flush_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= push_word;
    end
  end

  always_comb begin
    packet_ready_o = ready;
    word_valid_o   = !empty;
    word_o         = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    fill_o         = fill_q;
    fifo_level_o   = level;
    busy_o         = (fill_q != '0) || !empty || flush_q;
  end

endmodule

// File: tb/tb_trdb_stream_packer.sv
// Bench for trdb_stream_packer: directed scenarios plus random traffic, checked by a
// scoreboard fed from a bit-queue reference model.
module tb_trdb_stream_packer;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned PKT_W  = 64;
  localparam int unsigned LEN_W  = 7;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [PKT_W-1:0]  pkt = '0;
  logic [LEN_W-1:0]  len = '0;
  logic              pv = 1'b0;
  logic              packet_ready_o;
  logic              flush = 1'b0;
  logic [WORD_W-1:0] word_o;
  logic              word_valid_o;
  logic              grant = 1'b0;
  logic [LEN_W:0]    fill_o;
  logic [2:0]        fifo_level_o;
  logic              busy_o;

  int checks = 0;
  int errors = 0;

  logic [WORD_W-1:0] exp_q[$];
  bit                model_bits[$];
  logic [WORD_W-1:0] mon_exp;
  logic [WORD_W-1:0] mon_w;

  trdb_stream_packer #(
    .WORD_W(WORD_W),
    .PKT_W (PKT_W),
    .LEN_W (LEN_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .packet_i      (pkt),
    .packet_len_i  (len),
    .packet_valid_i(pv),
    .packet_ready_o(packet_ready_o),
    .flush_i       (flush),
    .word_o        (word_o),
    .word_valid_o  (word_valid_o),
    .grant_i       (grant),
    .fill_o        (fill_o),
    .fifo_level_o  (fifo_level_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor + reference model: the stream is a bit queue, words are cut every WORD_W bits,
  // and a flush pads the queue with zeros to the next word boundary.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_bits.delete();
    end else begin
      assert (!(pv && (len > LEN_W'(PKT_W)))) else $error("FAIL illegal_len got %0d", len);
      if (word_valid_o && grant) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%08h expected none", word_o);
        end else begin
          mon_exp = exp_q.pop_front();
          check("word", 64'(word_o), 64'(mon_exp));
        end
      end
      if (pv && packet_ready_o) begin
        for (int i = 0; i < int'(len); i++) model_bits.push_back(pkt[i]);
      end
      if (flush) begin
        while ((model_bits.size() % WORD_W) != 0) model_bits.push_back(1'b0);
      end
      while (model_bits.size() >= WORD_W) begin
        for (int i = 0; i < int'(WORD_W); i++) mon_w[i] = model_bits.pop_front();
        exp_q.push_back(mon_w);
      end
    end
  end

  task automatic send(input logic [63:0] p, input logic [LEN_W-1:0] l, output bit ok);
    pv  = 1'b1;
    pkt = p;
    len = l;
    ok  = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (packet_ready_o) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    pv = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    grant = 1'b1;
    while ((busy_o || word_valid_o) && n < 200) begin
      tick();
      n++;
    end
    check(name, 64'(busy_o), 64'd0);
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_valid", 64'(word_valid_o), 64'd0);
    check("rst_fill", 64'(fill_o), 64'd0);
    check("rst_level", 64'(fifo_level_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_word", 64'(word_o), 64'd0);
    rst = 1'b0;
    tick();
    check("rst_ready", 64'(packet_ready_o), 64'd1);

    // 40-bit packet: first word after two cycles, then flush the remaining byte
    grant = 1'b1;
    pkt   = 64'h00AB_CDEF_0123_4567;
    len   = 7'd40;
    pv    = 1'b1;
    check("t2_ready", 64'(packet_ready_o), 64'd1);
    tick();
    pv = 1'b0;
    check("t2_valid_n1", 64'(word_valid_o), 64'd0);
    tick();
    check("t2_valid_n2", 64'(word_valid_o), 64'd1);
    check("t2_word", 64'(word_o), 64'h0123_4567);
    check("t2_fill", 64'(fill_o), 64'd8);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle("t2_idle");
    check("t2_fill_end", 64'(fill_o), 64'd0);

    // Two 16-bit packets with garbage in the masked upper bits
    send(64'hFFFF_FFFF_FFFF_BEEF, 7'd16, ok);
    check("t3_send1", 64'(ok), 64'd1);
    send(64'hFFFF_FFFF_FFFF_DEAD, 7'd16, ok);
    check("t3_send2", 64'(ok), 64'd1);
    wait_idle("t3_idle");
    check("t3_fill", 64'(fill_o), 64'd0);

    // Backpressure: FIFO fills, staging holds the fifth word, sixth packet stalls
    grant = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send(64'(i), 7'd32, ok);
      check("t4_send", 64'(ok), 64'd1);
    end
    check("t4_level", 64'(fifo_level_o), 64'd4);
    check("t4_fill", 64'(fill_o), 64'd32);
    check("t4_ready", 64'(packet_ready_o), 64'd0);
    pv  = 1'b1;
    pkt = 64'h6;
    len = 7'd32;
    repeat (3) tick();
    check("t4_stall", 64'(packet_ready_o), 64'd0);
    grant = 1'b1;
    send(64'h6, 7'd32, ok);
    check("t4_send6", 64'(ok), 64'd1);
    wait_idle("t4_idle");

    // Flush with nothing staged emits nothing
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("t5a_valid", 64'(word_valid_o), 64'd0);
    check("t5a_busy", 64'(busy_o), 64'd0);

    // Flush together with an accepted packet covers that packet
    pkt   = 64'hFFFF_FFFF_FFFF_FF5A;
    len   = 7'd8;
    pv    = 1'b1;
    flush = 1'b1;
    tick();
    pv    = 1'b0;
    flush = 1'b0;
    wait_idle("t5b_idle");

    // Flush after an exact two-word amount adds no padding word
    send(64'h1357_9BDF_2468_ACE0, 7'd64, ok);
    check("t5c_send", 64'(ok), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle("t5c_idle");
    check("t5c_ready", 64'(packet_ready_o), 64'd1);

    // Reset mid-stream discards the staged bits
    send(64'h00FF_EEDD_CCBB_AA99, 7'd24, ok);
    check("t6_fill", 64'(fill_o), 64'd24);
    rst = 1'b1;
    tick();
    check("t6_fill_rst", 64'(fill_o), 64'd0);
    check("t6_busy_rst", 64'(busy_o), 64'd0);
    check("t6_level_rst", 64'(fifo_level_o), 64'd0);
    check("t6_valid_rst", 64'(word_valid_o), 64'd0);
    rst = 1'b0;
    tick();
    check("t6_ready", 64'(packet_ready_o), 64'd1);
    repeat (5) tick();
    check("t6_no_word", 64'(word_valid_o), 64'd0);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      pkt   = {$urandom, $urandom};
      len   = LEN_W'($urandom_range(0, PKT_W));
      pv    = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 7) == 0);
      grant = ($urandom_range(0, 9) < 7);
      tick();
    end
    pv    = 1'b0;
    grant = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle("rand_idle");
    check("rand_model_bits", 64'(model_bits.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
